// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// State encoding is fixed so external checkers can decode state_q directly.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width: enough to count 0..width-1, never narrower than 1 bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder, the single arithmetic cell of the serial adder.
module fa_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop, LSB first.
// A start accepted in IDLE runs WIDTH BUSY cycles, then one DONE cycle with a
// done_o pulse. Results are registered and held until the next completion.
// Optional subtract mode is enabled by defining SERIAL_ADDER_SUB_EN, which adds
// the sub_i port (b is inverted bit by bit; cin_i=1 means no borrow-in).
//
// Handshake: start_i is a request sampled only in IDLE; requests arriving in
// BUSY or DONE are dropped. done_o is a one-cycle valid pulse for sum_o,
// cout_o and ovf_o; there is no back-pressure. busy_o and done_o are exclusive.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   a_sh_q;
    logic [WIDTH-1:0]   b_sh_q;
    // Upper WIDTH-1 bits of the partial sum; the bit that would fall off the
    // bottom of a full-width shifter is never needed, so it is not stored.
    logic [WIDTH-2:0]   s_sh_q;
    logic [WIDTH-1:0]   s_sh_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               ovf_q;
    logic               busy_q;
    logic               done_q;
    logic               b_bit;
    logic               fa_s;
    logic               fa_cout;

`ifdef SERIAL_ADDER_SUB_EN
    logic               sub_q;
    // Subtraction inverts b as it enters the cell: a + ~b + cin.
    assign b_bit = b_sh_q[0] ^ sub_q;
`else
    assign b_bit = b_sh_q[0];
`endif

    fa_cell u_fa (
        .a_i    (a_sh_q[0]),
        .b_i    (b_bit),
        .cin_i  (carry_q),
        .s_o    (fa_s),
        .cout_o (fa_cout)
    );

    // Partial sum after this bit: new bit enters at the MSB, older bits move down.
    assign s_sh_d = {fa_s, s_sh_q};

    // Control FSM, operand/sum shifters and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            s_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        a_sh_q  <= a_i;
                        b_sh_q  <= b_i;
                        carry_q <= cin_i;
                        cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                        sub_q   <= sub_i;
`endif
                        busy_q  <= 1'b1;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    carry_q <= fa_cout;
                    s_sh_q  <= s_sh_d[WIDTH-1:1];
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        sum_q   <= s_sh_d;
                        cout_q  <= fa_cout;
                        // carry_q here is the carry into the MSB.
                        ovf_q   <= carry_q ^ fa_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: an 8-bit instance (directed, hold-start,
// reset-abort and random ops) and a 4-bit instance (exhaustive). Expected
// results come from an integer reference model pushed into per-DUT queues; a
// monitor pops and compares on every done_o pulse.
module tb_serial_adder;

    localparam int W8 = 8;
    localparam int W4 = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          start8, cin8, busy8, done8, cout8, ovf8;
    logic [W8-1:0] a8, b8, sum8;
    logic          start4, cin4, busy4, done4, cout4, ovf4;
    logic [W4-1:0] a4, b4, sum4;
`ifdef SERIAL_ADDER_SUB_EN
    logic          sub8;
    logic          sub4;
`endif

    serial_adder #(.WIDTH(W8)) u_dut8 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start8),
        .a_i     (a8),
        .b_i     (b8),
        .cin_i   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub8),
`endif
        .busy_o  (busy8),
        .done_o  (done8),
        .sum_o   (sum8),
        .cout_o  (cout8),
        .ovf_o   (ovf8)
    );

    serial_adder #(.WIDTH(W4)) u_dut4 (
        .clk     (clk),
        .rst     (rst),
        .start_i (start4),
        .a_i     (a4),
        .b_i     (b4),
        .cin_i   (cin4),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub4),
`endif
        .busy_o  (busy4),
        .done_o  (done4),
        .sum_o   (sum4),
        .cout_o  (cout4),
        .ovf_o   (ovf4)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [W8+1:0] exp8_q[$];   // {ovf, cout, sum}
    logic [W4+1:0] exp4_q[$];
    logic [W8+1:0] last8;       // last completed 8-bit result, for stability checks

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Integer reference: exact sum/difference, then unsigned and signed range tests.
    function automatic void ref_model(input int w, input longint a, input longint b,
                                      input bit cin, input bit sub,
                                      output logic [63:0] sum, output logic co, output logic ov);
        longint m, half, sa, sb, full, sfull;
        m    = longint'(1) << w;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        if (sub) begin
            full  = a - b - (1 - longint'(cin));
            sfull = sa - sb - (1 - longint'(cin));
            co    = (full >= 0);
        end else begin
            full  = a + b + longint'(cin);
            sfull = sa + sb + longint'(cin);
            co    = (full >= m);
        end
        ov  = (sfull < -half) || (sfull >= half);
        sum = 64'(((full % m) + m) % m);
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("busy_done_excl8", 64'(busy8 & done8), 64'd0);
            check("busy_done_excl4", 64'(busy4 & done4), 64'd0);
            if (done8) begin
                if (exp8_q.size() == 0) check("stray_done8", 64'(done8), 64'd0);
                else check("result8", 64'({ovf8, cout8, sum8}), 64'(exp8_q.pop_front()));
            end
            if (done4) begin
                if (exp4_q.size() == 0) check("stray_done4", 64'(done4), 64'd0);
                else check("result4", 64'({ovf4, cout4, sum4}), 64'(exp4_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // One 8-bit operation; hold keeps start_i high through BUSY and DONE.
    task automatic issue8(input logic [W8-1:0] a, input logic [W8-1:0] b,
                          input logic cin, input logic sub, input logic hold);
        logic [63:0] s;
        logic co, ov;
        int cyc, busy_n;
        @(negedge clk);
        check("idle_before_start8", 64'(busy8), 64'd0);
        a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = sub;
`endif
        ref_model(W8, longint'(a), longint'(b), cin, sub, s, co, ov);
        exp8_q.push_back({ov, co, s[W8-1:0]});
        @(posedge clk); #1;
        if (!hold) start8 = 1'b0;
        // Inputs changing after acceptance must not matter.
        a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
        cyc = 0;
        busy_n = busy8 ? 1 : 0;
        check("stable8", 64'({ovf8, cout8, sum8}), 64'(last8));
        while (!done8 && cyc < 3 * W8) begin
            @(posedge clk); #1;
            cyc++;
            if (!done8) begin
                check("stable8", 64'({ovf8, cout8, sum8}), 64'(last8));
                if (busy8) busy_n++;
            end
        end
        check("latency8", 64'(cyc), 64'(W8));
        check("busy_cycles8", 64'(busy_n), 64'(W8));
        last8 = {ov, co, s[W8-1:0]};
        @(posedge clk); #1;
        start8 = 1'b0;
        check("idle_after_done8", 64'({busy8, done8}), 64'd0);
    endtask

    task automatic issue4(input logic [W4-1:0] a, input logic [W4-1:0] b, input logic cin);
        logic [63:0] s;
        logic co, ov;
        int cyc;
        @(negedge clk);
        a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
        ref_model(W4, longint'(a), longint'(b), cin, 1'b0, s, co, ov);
        exp4_q.push_back({ov, co, s[W4-1:0]});
        @(posedge clk); #1;
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 3 * W4) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("latency4", 64'(cyc), 64'(W4));
        @(posedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0; sub4 = 1'b0;
`endif
        last8 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outputs8", 64'({busy8, done8, ovf8, cout8, sum8}), 64'd0);
        check("reset_outputs4", 64'({busy4, done4, ovf4, cout4, sum4}), 64'd0);

        // Directed 8-bit vectors.
        issue8(8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        issue8(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        issue8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        issue8(8'h5A, 8'hA5, 1'b1, 1'b0, 1'b1);   // start held high throughout
        issue8(8'h80, 8'h80, 1'b0, 1'b0, 1'b0);
        issue8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);   // leaves nonzero outputs before reset

        // Reset on the 4th BUSY edge aborts the operation silently.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_outputs8", 64'({busy8, done8, ovf8, cout8, sum8}), 64'd0);
        last8 = '0;
        repeat (W8 + 3) @(posedge clk);   // any done pulse here is flagged as stray
        issue8(8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        issue8(8'h10, 8'h01, 1'b1, 1'b1, 1'b0);
        issue8(8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
        issue8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
`endif

        // Random 8-bit operations.
        for (int i = 0; i < 150; i++) begin
            logic sub_r;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r = 1'($urandom_range(1, 0));
`else
            sub_r = 1'b0;
`endif
            issue8(W8'($urandom), W8'($urandom), 1'($urandom_range(1, 0)), sub_r,
                   1'($urandom_range(7, 0) == 0));
        end

        // Exhaustive 4-bit addition.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    issue4(W4'(a), W4'(b), 1'(c));

        repeat (4) @(posedge clk);
        #1;
        check("queue8_drained", 64'(exp8_q.size()), 64'd0);
        check("queue4_drained", 64'(exp4_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
